// File: rtl/sdm_pkg.sv
// Shared constants, state encoding and saturation helper for the sigma-delta transmitter.
package sdm_pkg;

  localparam int FS_POS = 32768;
  localparam int FS_NEG = -32768;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sdm_state_e;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_e;

  // Classify a sign-extended sum against the signed range of an acc_w-bit integrator.
  function automatic sat_e saturate(input logic signed [63:0] v, input int unsigned acc_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return SAT_HI;
    if (v < lo) return SAT_LO;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/sdm_mclk_div.sv
// Modulator clock divider: owns div_cnt, the registered mclk and the per-period step strobe.
module sdm_mclk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_sdm,
  input  logic reset_sdm,
  input  logic run_sdm,
  output logic mclk_sdm,
  output logic step_c
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;

  // Divider counter and mclk; both return to zero whenever the block is not running.
  always_ff @(posedge clk_sdm or posedge reset_sdm) begin
    if (reset_sdm) begin
      div_cnt  <= '0;
      mclk_sdm <= 1'b0;
    end else if (!run_sdm) begin
      div_cnt  <= '0;
      mclk_sdm <= 1'b0;
    end else begin
      div_cnt  <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
      mclk_sdm <= (div_cnt < DIV_W'(CLK_DIV / 2));
    end
  end

  // The step lands on the same edge that raises mclk, so mdata settles a half period before the fall.
  always_comb begin
    step_c = run_sdm & (div_cnt == '0);
  end

endmodule

// File: rtl/sdm_bitstream_tx.sv
// Second-order sigma-delta modulator turning 16-bit samples into an MCLK/MDATA bitstream.
module sdm_bitstream_tx
  import sdm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ACC_W   = 24
) (
  input  logic        clk_sdm,
  input  logic        reset_sdm,
  input  logic        en_sdm,
  input  logic [15:0] dec_rate_sdm,
  input  logic [15:0] din_sdm,
  input  logic        din_valid_sdm,
  output logic        din_ready_sdm,
  output logic        mclk_sdm,
  output logic        mdata_sdm,
  output logic        underrun_sdm,
  output logic        overload_sdm,
  input  logic        clr_sdm
);

  localparam int unsigned SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] FB_POS  = SUM_W'(FS_POS);
  localparam logic signed [SUM_W-1:0] FB_NEG  = SUM_W'(FS_NEG);
  localparam logic signed [SUM_W-1:0] FB2_POS = SUM_W'(2 * FS_POS);
  localparam logic signed [SUM_W-1:0] FB2_NEG = SUM_W'(2 * FS_NEG);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

  sdm_state_e state_q, state_d;
  logic run_c, leave_c, step_c;

  logic signed [15:0]      x_q, pend_q;
  logic                    pend_full_q;
  logic [15:0]             hold_cnt_q, dr_eff_c;
  logic signed [ACC_W-1:0] i1_q, i2_q, i1_n_c, i2_n_c;
  logic signed [SUM_W-1:0] fb_c, fb2_c, s1_c, s2_c;
  sat_e                    sat1_c, sat2_c;
  logic xfer_c, wrap_c, urun_set_c, ovl_set_c;

  sdm_mclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_sdm   (clk_sdm),
    .reset_sdm (reset_sdm),
    .run_sdm   (run_c),
    .mclk_sdm  (mclk_sdm),
    .step_c    (step_c)
  );

  // FSM state register.
  always_ff @(posedge clk_sdm or posedge reset_sdm) begin
    if (reset_sdm) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FSM next state: enable alone moves between IDLE and RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_sdm)  state_d = RUN;
      RUN:     if (!en_sdm) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: run only while enabled; the dropping edge clears the loop instead of stepping.
  always_comb begin
    run_c   = 1'b0;
    leave_c = 1'b0;
    case (state_q)
      RUN: begin
        run_c   = en_sdm;
        leave_c = ~en_sdm;
      end
      default: ;
    endcase
  end

  // Loop filter arithmetic, hold-period wrap and flag set events for this cycle.
  always_comb begin
    fb_c     = mdata_sdm ? FB_POS  : FB_NEG;
    fb2_c    = mdata_sdm ? FB2_POS : FB2_NEG;
    s1_c     = SUM_W'(i1_q) + SUM_W'(x_q) - fb_c;
    sat1_c   = saturate(64'(s1_c), ACC_W);
    i1_n_c   = (sat1_c == SAT_HI) ? ACC_MAX : (sat1_c == SAT_LO) ? ACC_MIN : s1_c[ACC_W-1:0];
    s2_c     = SUM_W'(i2_q) + SUM_W'(i1_n_c) - fb2_c;
    sat2_c   = saturate(64'(s2_c), ACC_W);
    i2_n_c   = (sat2_c == SAT_HI) ? ACC_MAX : (sat2_c == SAT_LO) ? ACC_MIN : s2_c[ACC_W-1:0];
    dr_eff_c   = (dec_rate_sdm == 16'd0) ? 16'd1 : dec_rate_sdm;
    xfer_c     = din_valid_sdm & din_ready_sdm;
    wrap_c     = step_c & (hold_cnt_q >= dr_eff_c - 16'd1);
    urun_set_c = wrap_c & ~pend_full_q & ~xfer_c;
    ovl_set_c  = step_c & ((sat1_c != SAT_NONE) | (sat2_c != SAT_NONE));
  end

  // Integrators, bitstream output and hold counter.
  always_ff @(posedge clk_sdm or posedge reset_sdm) begin
    if (reset_sdm) begin
      i1_q       <= '0;
      i2_q       <= '0;
      mdata_sdm  <= 1'b0;
      hold_cnt_q <= '0;
    end else if (leave_c) begin
      i1_q       <= '0;
      i2_q       <= '0;
      mdata_sdm  <= 1'b0;
      hold_cnt_q <= '0;
    end else if (step_c) begin
      i1_q       <= i1_n_c;
      i2_q       <= i2_n_c;
      mdata_sdm  <= ~i2_n_c[ACC_W-1];
      hold_cnt_q <= wrap_c ? '0 : hold_cnt_q + 16'd1;
    end
  end

  // Sample handshake: pend buffers one sample, promoted to x on each hold wrap.
  always_ff @(posedge clk_sdm or posedge reset_sdm) begin
    if (reset_sdm) begin
      x_q           <= '0;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      din_ready_sdm <= 1'b1;
    end else if (wrap_c && pend_full_q) begin
      x_q           <= pend_q;
      pend_full_q   <= 1'b0;
      din_ready_sdm <= 1'b1;
    end else if (wrap_c && xfer_c) begin
      x_q           <= din_sdm;
      din_ready_sdm <= 1'b0;
    end else if (xfer_c) begin
      pend_q        <= din_sdm;
      pend_full_q   <= 1'b1;
      din_ready_sdm <= 1'b0;
    end else if (!pend_full_q) begin
      din_ready_sdm <= 1'b1;
    end
  end

  // Sticky flags; a set event in the same cycle overrides the clear.
  always_ff @(posedge clk_sdm or posedge reset_sdm) begin
    if (reset_sdm) begin
      underrun_sdm <= 1'b0;
      overload_sdm <= 1'b0;
    end else begin
      underrun_sdm <= urun_set_c | (underrun_sdm & ~clr_sdm);
      overload_sdm <= ovl_set_c  | (overload_sdm & ~clr_sdm);
    end
  end

endmodule

// File: tb/tb_sdm_bitstream_tx.sv
// Self-checking bench for sdm_bitstream_tx against an arithmetic reference of the modulator.
module tb_sdm_bitstream_tx;

  localparam int CLK_DIV = 4;
  localparam int ACC_W   = 24;
  localparam longint ACC_HI = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint ACC_LO = -(64'sd1 <<< (ACC_W - 1));

  logic clk = 1'b0;
  logic rst, en, vld, clr;
  logic [15:0] dr, din;
  logic ready, mclk, mdata, urun, ovl;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  bit     m_state, m_mclk, m_mdata, m_ready, m_urun, m_ovl;
  int     m_cyc, m_hold, m_wraps, m_x;
  longint m_i1, m_i2;
  int     pend[$];

  always #5 clk = ~clk;

  sdm_bitstream_tx #(.CLK_DIV(CLK_DIV), .ACC_W(ACC_W)) dut (
    .clk_sdm       (clk),
    .reset_sdm     (rst),
    .en_sdm        (en),
    .dec_rate_sdm  (dr),
    .din_sdm       (din),
    .din_valid_sdm (vld),
    .din_ready_sdm (ready),
    .mclk_sdm      (mclk),
    .mdata_sdm     (mdata),
    .underrun_sdm  (urun),
    .overload_sdm  (ovl),
    .clr_sdm       (clr)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clampv(input longint v);
    if (v > ACC_HI) return ACC_HI;
    if (v < ACC_LO) return ACC_LO;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cyc = 0; m_mclk = 0; m_mdata = 0; m_ready = 1;
    m_urun = 0; m_ovl = 0; m_i1 = 0; m_i2 = 0; m_x = 0; m_hold = 0; m_wraps = 0;
    pend.delete();
  endtask

  function automatic bit pred_wrap();
    int drv;
    drv = (dr == 16'd0) ? 1 : int'(dr);
    return m_state && en && (m_cyc % CLK_DIV == 0) && (m_hold + 1 >= drv);
  endfunction

  // Advance the reference by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit xfer, done, us, os;
    int ph, fb, drv;
    longint a, c;
    xfer = vld && m_ready;
    done = 0; us = 0; os = 0;
    if (m_state && en) begin
      ph = m_cyc % CLK_DIV;
      m_mclk = (ph < CLK_DIV / 2);
      m_cyc++;
      if (ph == 0) begin
        fb = m_mdata ? 32768 : -32768;
        a = m_i1 + m_x - fb;
        c = clampv(a); if (c != a) os = 1; m_i1 = c;
        a = m_i2 + m_i1 - 2 * fb;
        c = clampv(a); if (c != a) os = 1; m_i2 = c;
        m_mdata = (m_i2 >= 0);
        drv = (dr == 16'd0) ? 1 : int'(dr);
        if (m_hold + 1 >= drv) begin
          m_hold = 0; m_wraps++; done = 1;
          if (pend.size() > 0) begin m_x = pend.pop_front(); m_ready = 1; end
          else if (xfer) begin m_x = int'($signed(din)); m_ready = 0; end
          else us = 1;
        end else begin
          m_hold++;
        end
      end
    end else if (m_state) begin
      m_state = 0; m_cyc = 0; m_mclk = 0; m_mdata = 0; m_i1 = 0; m_i2 = 0; m_hold = 0;
    end else begin
      m_state = en;
    end
    if (!done) begin
      if (xfer) begin pend.push_back(int'($signed(din))); m_ready = 0; end
      else if (pend.size() == 0) m_ready = 1;
    end
    m_urun = us | (m_urun & !clr);
    m_ovl  = os | (m_ovl & !clr);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("cycle", 64'({mclk, mdata, ready, urun, ovl}),
          64'({m_mclk, m_mdata, m_ready, m_urun, m_ovl}));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; en = 0; vld = 0; clr = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic run_ones(input int d, input int exp_ones);
    int ones, hi, rises;
    bit prev;
    do_reset();
    dr = 16'd32; din = 16'(d); vld = 1; en = 1;
    repeat (96 * CLK_DIV) tick();
    ones = 0; hi = 0; rises = 0; prev = mclk;
    repeat (1024 * CLK_DIV) begin
      tick();
      if (mclk && !prev) begin rises++; ones += int'(mdata); end
      hi += int'(mclk);
      prev = mclk;
    end
    check($sformatf("ones_in_tol din=%0d count=%0d want=%0d", d, ones, exp_ones),
          64'((ones >= exp_ones - 4) && (ones <= exp_ones + 4)), 1);
    check("mclk_rises", rises, 1024);
    check("mclk_high", hi, 2048);
    check("urun_fed", urun, 0);
  endtask

  initial begin
    int dr_tab[5] = '{0, 1, 2, 3, 7};
    rst = 1; en = 0; vld = 0; clr = 0; dr = 16'd1; din = 16'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_vals", 64'({mclk, mdata, ready, urun, ovl}), 64'(5'b00100));
    @(negedge clk);
    rst = 0;

    // dec_rate 1 with no samples: every step wraps empty.
    en = 1;
    repeat (12) tick();
    check("urun_dr1", urun, 1);
    #2 rst = 1;
    #1 check("async_rst", 64'({mclk, mdata, ready, urun, ovl}), 64'(5'b00100));
    model_reset();
    @(negedge clk);
    rst = 0;
    tick(); check("mclk_e0", mclk, 0);
    tick(); check("mclk_e1", mclk, 1);

    run_ones(0, 512);
    run_ones(16384, 768);
    run_ones(-16384, 256);

    // One sample, then starve the hold register.
    do_reset();
    dr = 16'd4; din = 16'h1234; vld = 1; en = 1;
    tick();
    vld = 0;
    for (int i = 0; i < 200 && m_wraps < 1; i++) tick();
    check("urun_wrap1", urun, 0);
    for (int i = 0; i < 200 && m_wraps < 2; i++) tick();
    check("urun_wrap2", urun, 1);
    check("wrap_count", m_wraps, 2);
    clr = 1; tick(); clr = 0;
    check("urun_clr", urun, 0);

    // Sample arriving on a wrap edge with pend empty goes straight to x.
    for (int i = 0; i < 200 && !(pred_wrap() && m_ready); i++) tick();
    check("direct_found", 64'(pred_wrap() && m_ready), 1);
    vld = 1; din = 16'hEC78;
    tick();
    vld = 0;
    check("direct_urun", urun, 0);
    check("direct_rdy0", ready, 0);
    tick();
    check("direct_rdy1", ready, 1);
    repeat (40) tick();

    // Shrinking dec_rate below the current hold count wraps on the next step.
    dr = 16'd8;
    for (int i = 0; i < 400 && m_hold != 6; i++) tick();
    clr = 1; tick(); clr = 0;
    check("dr_pre", urun, 0);
    dr = 16'd3;
    repeat (CLK_DIV) tick();
    check("dr_shrink", urun, 1);

    // Sustained near full scale.
    do_reset();
    din = 16'd32767; dr = 16'd1; vld = 1; en = 1;
    repeat (4096 * CLK_DIV) tick();
    check("ovl_fullscale", ovl, m_ovl);

    // Randomized traffic, rate changes, clears and enable drops.
    do_reset();
    en = 1;
    for (int i = 0; i < 3000; i++) begin
      vld = 1'($urandom_range(0, 1));
      din = 16'($urandom);
      clr = ($urandom_range(0, 31) == 0);
      if (i % 200 == 0) dr = 16'(dr_tab[$urandom_range(0, 4)]);
      en = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
